sha256_round_ctrl: RTL and testbench

//  Sequencer for the SHA-256 compression datapath. Accepts one 512-bit block per handshake.

---
 rtl/sha256_round_ctrl.sv | 112 +++++++++++
 tb/tb_sha256_round_ctrl.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha256_round_ctrl.sv
// SHA-256 compression sequencer: block handshake, 64-round counter,
// W/K mux selects, load/round/update strobes and digest hand-off.
module sha256_round_ctrl #(
  parameter int ROUNDS = 64,
  parameter int CW     = 6
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          msg_valid,
  input  logic          first_block,
  input  logic          last_block,
  output logic          msg_ready,
  input  logic          abort,
  output logic [CW-1:0] sel_w,
  output logic [CW-1:0] sel_k,
  output logic [CW-1:0] round_idx,
  output logic          init_iv,
  output logic          init_state,
  output logic          round_en,
  output logic          h_update,
  output logic          digest_valid,
  input  logic          digest_ready,
  output logic          busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_ROUND,
    S_UPDATE,
    S_DONE
  } state_t;

  localparam logic [CW-1:0] LAST = CW'(ROUNDS - 1);

  state_t        r_state;
  state_t        w_next;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt;
  logic          r_first;
  logic          r_last;
  logic          w_accept;
  logic          w_last_rnd;

  assign w_accept   = (r_state == S_IDLE) & msg_valid & ~abort;
  assign w_last_rnd = (r_cnt == LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_first <= 1'b0;
      r_last  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt;
      if (w_accept) begin
        r_first <= first_block;
        r_last  <= last_block;
      end
    end
  end

  always_comb begin
    w_next = r_state;
    w_cnt  = r_cnt;
    unique case (r_state)
      S_IDLE: begin
        if (msg_valid) w_next = S_INIT;
      end
      S_INIT: begin
        w_next = S_ROUND;
        w_cnt  = '0;
      end
      S_ROUND: begin
        if (w_last_rnd) begin
          w_next = S_UPDATE;
          w_cnt  = '0;
        end else begin
          w_cnt = r_cnt + 1'b1;
        end
      end
      S_UPDATE: begin
        w_next = r_last ? S_DONE : S_IDLE;
      end
      S_DONE: begin
        if (digest_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
    // abort overrides everything, including an IDLE accept
    if (abort) begin
      w_next = S_IDLE;
      w_cnt  = '0;
    end
  end

  assign msg_ready    = (r_state == S_IDLE);
  assign busy         = (r_state != S_IDLE);
  assign digest_valid = (r_state == S_DONE);

  assign init_iv    = (r_state == S_INIT) & r_first & ~abort;
  assign init_state = (r_state == S_INIT) & ~r_first & ~abort;
  assign round_en   = (r_state == S_ROUND) & ~abort;
  assign h_update   = (r_state == S_UPDATE) & ~abort;

  // K mux is reverse-indexed: select 63 picks K[0]
  assign round_idx = r_cnt;
  assign sel_w     = r_cnt;
  assign sel_k     = ~r_cnt;

endmodule

// File: tb/tb_sha256_round_ctrl.sv
// Bench for sha256_round_ctrl: drives blocks, models the W/K/H datapath
// from the strobes, and scoreboards strobe timing and final digests.
module tb_sha256_round_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       msg_valid;
  logic       first_block;
  logic       last_block;
  logic       msg_ready;
  logic       abort;
  logic [5:0] sel_w;
  logic [5:0] sel_k;
  logic [5:0] round_idx;
  logic       init_iv;
  logic       init_state;
  logic       round_en;
  logic       h_update;
  logic       digest_valid;
  logic       digest_ready;
  logic       busy;

  sha256_round_ctrl #(.ROUNDS(64), .CW(6)) dut (
    .clk(clk), .reset(reset),
    .msg_valid(msg_valid), .first_block(first_block),
    .last_block(last_block), .msg_ready(msg_ready),
    .abort(abort), .sel_w(sel_w), .sel_k(sel_k),
    .round_idx(round_idx), .init_iv(init_iv),
    .init_state(init_state), .round_en(round_en),
    .h_update(h_update), .digest_valid(digest_valid),
    .digest_ready(digest_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  localparam logic [31:0] KC [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam logic [255:0] IV =
    256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
  localparam logic [255:0] ABC_DIG =
    256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [255:0] rnd(input logic [255:0] s,
                                       input logic [31:0] w,
                                       input logic [31:0] k);
    logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
    {a, b, c, d, e, f, g, h} = s;
    t1 = h + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25))
           + ((e & f) ^ (~e & g)) + k + w;
    t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22))
           + ((a & b) ^ (a & c) ^ (b & c));
    return {t1 + t2, a, b, c, d + t1, e, f, g};
  endfunction

  function automatic logic [2047:0] expand(input logic [511:0] b);
    logic [31:0]   w [64];
    logic [31:0]   s0, s1;
    logic [2047:0] r;
    for (int t = 0; t < 16; t++) w[t] = b[511-32*t -: 32];
    for (int t = 16; t < 64; t++) begin
      s0 = rotr(w[t-15], 7) ^ rotr(w[t-15], 18) ^ (w[t-15] >> 3);
      s1 = rotr(w[t-2], 17) ^ rotr(w[t-2], 19) ^ (w[t-2] >> 10);
      w[t] = w[t-16] + s0 + w[t-7] + s1;
    end
    for (int t = 0; t < 64; t++) r[32*t +: 32] = w[t];
    return r;
  endfunction

  function automatic logic [255:0] add8(input logic [255:0] x,
                                        input logic [255:0] y);
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[32*i +: 32] = x[32*i +: 32] + y[32*i +: 32];
    return r;
  endfunction

  function automatic logic [255:0] compress(input logic [255:0] h,
                                            input logic [511:0] b);
    logic [2047:0] ws;
    logic [255:0]  s;
    ws = expand(b);
    s  = h;
    for (int t = 0; t < 64; t++) s = rnd(s, ws[32*t +: 32], KC[t]);
    return add8(h, s);
  endfunction

  // Datapath model steered only by the controller's strobes and selects
  logic [2047:0] sched;
  logic [255:0]  m_h;
  logic [255:0]  m_s;

  always @(posedge clk) begin
    if (init_iv) begin
      m_h <= IV;
      m_s <= IV;
    end else if (init_state) begin
      m_s <= m_h;
    end else if (round_en) begin
      m_s <= rnd(m_s, sched[32*int'(sel_w) +: 32], KC[~sel_k]);
    end
    if (h_update) m_h <= add8(m_h, m_s);
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int           kind;
    int           cyc;
    int           idx;
    logic [255:0] dig;
  } ev_t;

  ev_t q[$];
  int  err = 0;
  int  chk = 0;

  task automatic check(input bit ok, input string nm,
                       input logic [255:0] act, input logic [255:0] exp);
    chk++;
    if (!ok) begin
      err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic obs(input int kind, input int idx);
    ev_t e;
    if (q.size() == 0) begin
      check(1'b0, "unexpected_event", 256'({kind, cyc, idx}), 256'(0));
      return;
    end
    e = q.pop_front();
    check(e.kind == kind && e.cyc == cyc && e.idx == idx, "event_seq",
          256'({kind, cyc, idx}), 256'({e.kind, e.cyc, e.idx}));
    if (kind == 3)
      check(sel_w == 6'(idx) && sel_k == ~6'(idx), "mux_sel",
            256'({sel_w, sel_k}), 256'({6'(idx), ~6'(idx)}));
    if (kind == 5) check(m_h == e.dig, "digest", m_h, e.dig);
  endtask

  task automatic monitor();
    bit pdv = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        pdv = 1'b0;
        continue;
      end
      if (init_iv)    obs(1, 0);
      if (init_state) obs(2, 0);
      if (round_en)   obs(3, int'(round_idx));
      if (h_update)   obs(4, 0);
      if (digest_valid && !pdv) obs(5, 0);
      pdv = digest_valid;
    end
  endtask

  task automatic send_block(input logic [511:0] blk, input bit f,
                            input bit l, input logic [255:0] dig,
                            input bit full, output int acc);
    int n = 0;
    acc = -1;
    do begin
      @(negedge clk);
      n++;
    end while (!msg_ready && n < 300);
    if (!msg_ready) begin
      check(1'b0, "accept_timeout", 256'(0), 256'(1));
      return;
    end
    sched       = expand(blk);
    msg_valid   = 1'b1;
    first_block = f;
    last_block  = l;
    acc         = cyc;
    q.push_back('{f ? 1 : 2, acc + 1, 0, '0});
    for (int t = 0; t < (full ? 64 : 63); t++)
      q.push_back('{3, acc + 2 + t, t, '0});
    if (full) begin
      q.push_back('{4, acc + 66, 0, '0});
      if (l) q.push_back('{5, acc + 67, 0, dig});
    end
    @(posedge clk);
    #1;
    msg_valid   = 1'b0;
    first_block = 1'($urandom);
    last_block  = 1'($urandom);
  endtask

  task automatic take_digest(input bit bp);
    logic [255:0] hs;
    int n = 0;
    while (!digest_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!digest_valid) begin
      check(1'b0, "digest_timeout", 256'(0), 256'(1));
      return;
    end
    if (bp) begin
      msg_valid = 1'b1;
      hs = m_h;
      repeat (10) begin
        @(negedge clk);
        check(digest_valid && !msg_ready && m_h == hs, "bp_hold",
              256'({digest_valid, msg_ready}), 256'({1'b1, 1'b0}));
      end
    end else begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    msg_valid    = 1'b0;
    digest_ready = 1'b1;
    @(posedge clk);
    #1;
    digest_ready = 1'b0;
    @(negedge clk);
    check(!digest_valid && msg_ready, "digest_release",
          256'({digest_valid, msg_ready}), 256'({1'b0, 1'b1}));
  endtask

  task automatic run_msg(input int nblk, input bit bp);
    logic [255:0] h = IV;
    logic [511:0] b;
    int acc, pacc = 0;
    for (int i = 0; i < nblk; i++) begin
      for (int j = 0; j < 16; j++) b[32*j +: 32] = $urandom();
      h = compress(h, b);
      send_block(b, i == 0, i == nblk - 1, h, 1'b1, acc);
      if (i > 0)
        check(acc == pacc + 67, "block_to_block", 256'(acc), 256'(pacc + 67));
      pacc = acc;
    end
    take_digest(bp);
  endtask

  initial begin
    logic [511:0] blk;
    int acc, n;
    reset        = 1'b0;
    msg_valid    = 1'b0;
    first_block  = 1'b0;
    last_block   = 1'b0;
    abort        = 1'b0;
    digest_ready = 1'b0;
    sched        = '0;
    fork
      monitor();
    join_none

    repeat (3) @(posedge clk);
    #1;
    check(!busy && round_idx == 0 && sel_k == 6'h3f && sel_w == 0,
          "reset_state", 256'({busy, round_idx, sel_k, sel_w}),
          256'({1'b0, 6'h00, 6'h3f, 6'h00}));
    check({init_iv, init_state, round_en, h_update, digest_valid} == 5'b0,
          "reset_strobes",
          256'({init_iv, init_state, round_en, h_update, digest_valid}),
          256'(0));
    reset = 1'b1;
    @(negedge clk);
    check(msg_ready == 1'b1, "ready_after_reset", 256'(msg_ready), 256'(1));

    blk = {32'h61626380, 448'h0, 32'h00000018};
    send_block(blk, 1'b1, 1'b1, ABC_DIG, 1'b1, acc);
    take_digest(1'b1);

    run_msg(2, 1'b0);
    for (int m = 0; m < 3; m++)
      run_msg($urandom_range(1, 3), 1'($urandom_range(0, 1)));

    for (int j = 0; j < 16; j++) blk[32*j +: 32] = $urandom();
    send_block(blk, 1'b1, 1'b1, '0, 1'b0, acc);
    while (cyc < acc + 65) begin
      @(posedge clk);
      #1;
    end
    abort = 1'b1;
    @(negedge clk);
    check(round_idx == 6'd63 && !round_en && !h_update, "abort_gate",
          256'({round_idx, round_en, h_update}), 256'({6'd63, 2'b00}));
    @(posedge clk);
    #1;
    abort = 1'b0;
    check(!busy && msg_ready && round_idx == 0, "abort_idle",
          256'({busy, msg_ready, round_idx}), 256'({1'b0, 1'b1, 6'd0}));
    repeat (3) @(negedge clk);
    abort        = 1'b1;
    msg_valid    = 1'b1;
    first_block  = 1'b1;
    last_block   = 1'b1;
    digest_ready = 1'b1;
    @(posedge clk);
    #1;
    abort        = 1'b0;
    msg_valid    = 1'b0;
    digest_ready = 1'b0;
    check(!busy && msg_ready, "abort_wins",
          256'({busy, msg_ready}), 256'({1'b0, 1'b1}));
    repeat (3) @(negedge clk);

    for (int j = 0; j < 16; j++) blk[32*j +: 32] = $urandom();
    send_block(blk, 1'b1, 1'b1, compress(IV, blk), 1'b1, acc);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(round_en && round_idx == 6'd30) && n < 100);
    check(round_idx == 6'd30, "reach_t30", 256'(round_idx), 256'(30));
    #2;
    reset = 1'b0;
    q.delete();
    #1;
    check(!busy && round_idx == 0 && sel_k == 6'h3f && !round_en,
          "async_reset", 256'({busy, round_idx, sel_k, round_en}),
          256'({1'b0, 6'd0, 6'h3f, 1'b0}));
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    check(msg_ready && !digest_valid, "ready_after_midreset",
          256'({msg_ready, digest_valid}), 256'({1'b1, 1'b0}));

    run_msg(1, 1'b0);

    repeat (3) @(negedge clk);
    check(q.size() == 0, "scoreboard_drained", 256'(q.size()), 256'(0));
    $display("Result: errors=%0d of %0d checks", err, chk);
    $finish;
  end

endmodule
